// File: rtl/mwi_pkg.sv
// Shared types and helpers for the moving-window integrator: state encoding,
// default sizing and window-length sanitising.
package mwi_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int MAX_WINDOW_DEF  = 64;
  localparam int RECIP_WIDTH_DEF = 16;
  localparam int PTR_W           = $clog2(MAX_WINDOW_DEF);
  localparam int SUM_WIDTH_DEF   = DATA_WIDTH_DEF + PTR_W;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A zero-length window degenerates to a pass-through of one sample.
  function automatic int unsigned clamp_win_len(input int unsigned len,
                                                input int unsigned max_win);
    if (len == 0) return 1;
    if (len > max_win) return max_win;
    return len;
  endfunction

endpackage

// File: rtl/mwi_delay_line.sv
// Circular sample buffer: asynchronous read of the oldest sample at ptr,
// synchronous write of the new sample to the same slot; wraps at win_len.
module mwi_delay_line
  import mwi_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  MAX_WINDOW = MAX_WINDOW_DEF,
  localparam int PTR_BITS   = $clog2(MAX_WINDOW),
  localparam int LEN_BITS   = PTR_BITS + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  adv,
  input  logic [LEN_BITS-1:0]   win_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [MAX_WINDOW];
  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic                  last_slot;

  assign last_slot = ({1'b0, ptr_q} == (win_len - LEN_BITS'(1)));

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = last_slot ? '0 : ptr_q + PTR_BITS'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // NOTE: the sample store has no reset; FILL masks stale contents, and
  // leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (adv) begin
      mem_q[ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[ptr_q];

endmodule

// File: rtl/mwi_stream.sv
// Moving-window integrator: running sum over a run-time window with optional
// reciprocal normalisation; three-register pipeline from sample to output.
module mwi_stream
  import mwi_pkg::*;
#(
  parameter int  DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int  MAX_WINDOW  = MAX_WINDOW_DEF,
  parameter int  RECIP_WIDTH = RECIP_WIDTH_DEF,
  parameter int  SUM_WIDTH   = DATA_WIDTH + $clog2(MAX_WINDOW),
  localparam int LEN_BITS    = $clog2(MAX_WINDOW) + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   cfg_load,
  input  logic [LEN_BITS-1:0]    cfg_win_len,
  input  logic                   cfg_avg,
  input  logic [RECIP_WIDTH-1:0] cfg_recip,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  output logic [SUM_WIDTH-1:0]   m_data,
  output logic                   m_full
);

  localparam int                    PROD_W  = SUM_WIDTH + RECIP_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = '1;

  // Configuration
  logic [LEN_BITS-1:0]    win_len_q, win_len_d, win_len_cfg;
  logic                   avg_q, avg_d;
  logic [RECIP_WIDTH-1:0] recip_q, recip_d;

  // Stage 1: running sum
  state_e                 state_q, state_d;
  logic [LEN_BITS-1:0]    fill_cnt_q, fill_cnt_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_full_q, s1_full_d;

  // Stage 2: sum capture, then output formatting
  logic                   s2_valid_q, s2_valid_d;
  logic [SUM_WIDTH-1:0]   s2_sum_q, s2_sum_d;
  logic                   s2_full_q, s2_full_d;
  logic                   m_valid_q, m_valid_d;
  logic [SUM_WIDTH-1:0]   m_data_q, m_data_d;
  logic                   m_full_q, m_full_d;

  logic                   cfg_fire, accept;
  logic [DATA_WIDTH-1:0]  rd_data, oldest;
  logic [PROD_W-1:0]      prod, avg_full;
  logic [SUM_WIDTH-1:0]   out_data;

  assign cfg_fire    = en & cfg_load;
  assign accept      = en & s_valid & ~cfg_load;
  assign win_len_cfg = LEN_BITS'(clamp_win_len(32'(cfg_win_len), MAX_WINDOW));
  assign oldest      = (state_q == RUN) ? rd_data : '0;

  mwi_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_WINDOW (MAX_WINDOW)
  ) u_delay_line (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (cfg_fire),
    .adv     (accept),
    .win_len (win_len_q),
    .wr_data (s_data),
    .rd_data (rd_data)
  );

  always_comb begin
    win_len_d  = win_len_q;
    avg_d      = avg_q;
    recip_d    = recip_q;
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    sum_d      = sum_q;
    s1_valid_d = s1_valid_q;
    s1_full_d  = s1_full_q;
    if (cfg_fire) begin
      win_len_d  = win_len_cfg;
      avg_d      = cfg_avg;
      recip_d    = cfg_recip;
      state_d    = FILL;
      fill_cnt_d = '0;
      sum_d      = '0;
      s1_valid_d = 1'b0;
    end else if (en) begin
      s1_valid_d = s_valid;
      if (s_valid) begin
        // Add newest, drop oldest; during FILL the oldest term is zero.
        sum_d = sum_q + SUM_WIDTH'(s_data) - SUM_WIDTH'(oldest);
        if (state_q == FILL) begin
          if (fill_cnt_q == (win_len_q - LEN_BITS'(1))) begin
            state_d = RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + LEN_BITS'(1);
          end
        end
        s1_full_d = (state_d == RUN);
      end
    end
  end

  assign prod     = PROD_W'(s2_sum_q) * PROD_W'(recip_q);
  assign avg_full = prod >> RECIP_WIDTH;

  always_comb begin
    out_data = s2_sum_q;
    if (avg_q) begin
      if (avg_full > PROD_W'(SAT_MAX)) begin
        out_data = SUM_WIDTH'(SAT_MAX);
      end else begin
        out_data = SUM_WIDTH'(avg_full);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_full_d  = s2_full_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_full_d   = m_full_q;
    if (cfg_fire) begin
      // A reconfiguration discards anything still in flight.
      s2_valid_d = 1'b0;
      m_valid_d  = 1'b0;
    end else if (en) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = sum_q;
      s2_full_d  = s1_full_q;
      m_valid_d  = s2_valid_q;
      m_data_d   = out_data;
      m_full_d   = s2_full_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_len_q  <= LEN_BITS'(MAX_WINDOW);
      avg_q      <= 1'b0;
      recip_q    <= '0;
      state_q    <= FILL;
      fill_cnt_q <= '0;
      sum_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_full_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_full_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_full_q   <= 1'b0;
    end else begin
      win_len_q  <= win_len_d;
      avg_q      <= avg_d;
      recip_q    <= recip_d;
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      sum_q      <= sum_d;
      s1_valid_q <= s1_valid_d;
      s1_full_q  <= s1_full_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_full_q  <= s2_full_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_full_q   <= m_full_d;
    end
  end

  // A result held while disabled stays hidden until en returns, and is shown
  // exactly once because the next enabled edge replaces it.
  assign m_valid = m_valid_q & en;
  assign m_data  = m_data_q;
  assign m_full  = m_full_q;

endmodule

// File: tb/tb_mwi_stream.sv
// Directed, table-driven bench for mwi_stream: per-cycle stimulus rows with
// hand-computed expected outputs, plus long-window and async-reset sequences.
module tb_mwi_stream;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        cfg_load;
  logic [6:0]  cfg_win_len;
  logic        cfg_avg;
  logic [15:0] cfg_recip;
  logic        s_valid;
  logic [15:0] s_data;
  logic        m_valid;
  logic [21:0] m_data;
  logic        m_full;

  int n_checks = 0;
  int n_pass   = 0;

  mwi_stream dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .cfg_load    (cfg_load),
    .cfg_win_len (cfg_win_len),
    .cfg_avg     (cfg_avg),
    .cfg_recip   (cfg_recip),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_full      (m_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [6:0]  wl;
    logic        avg;
    logic [15:0] recip;
    logic        sv;
    logic [15:0] sd;
    logic        ev;
    logic [21:0] ed;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic e, input logic ld, input logic [6:0] wl,
                               input logic avg, input logic [15:0] recip,
                               input logic sv, input logic [15:0] sd,
                               input logic ev, input logic [21:0] ed, input logic ef);
    vec_t r;
    r.en = e; r.ld = ld; r.wl = wl; r.avg = avg; r.recip = recip;
    r.sv = sv; r.sd = sd; r.ev = ev; r.ed = ed; r.ef = ef;
    return r;
  endfunction

  function automatic vec_t smp(input logic [15:0] d, input logic ev,
                               input logic [21:0] ed, input logic ef);
    return row(1'b1, 1'b0, 7'd0, 1'b0, 16'd0, 1'b1, d, ev, ed, ef);
  endfunction

  function automatic vec_t idl(input logic ev, input logic [21:0] ed, input logic ef);
    return row(1'b1, 1'b0, 7'd0, 1'b0, 16'd0, 1'b0, 16'd0, ev, ed, ef);
  endfunction

  // Disabled cycle with a live strobe that must be ignored.
  function automatic vec_t gap();
    return row(1'b0, 1'b0, 7'd0, 1'b0, 16'd0, 1'b1, 16'd99, 1'b0, 22'd0, 1'b0);
  endfunction

  function automatic vec_t ld(input logic [6:0] wl, input logic avg,
                              input logic [15:0] recip, input logic sv,
                              input logic [15:0] sd);
    return row(1'b1, 1'b1, wl, avg, recip, sv, sd, 1'b0, 22'd0, 1'b0);
  endfunction

  // Drive on the falling edge, let one rising edge pass, sample on the next fall.
  task automatic apply_row(input vec_t r, input string tag);
    en          = r.en;
    cfg_load    = r.ld;
    cfg_win_len = r.wl;
    cfg_avg     = r.avg;
    cfg_recip   = r.recip;
    s_valid     = r.sv;
    s_data      = r.sd;
    @(posedge clk);
    @(negedge clk);
    check({tag, " m_valid"}, 32'(m_valid), 32'(r.ev));
    if (r.ev) begin
      check({tag, " m_data"}, 32'(m_data), 32'(r.ed));
      check({tag, " m_full"}, 32'(m_full), 32'(r.ef));
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_win_len = '0;
    cfg_avg = 1'b0; cfg_recip = '0; s_valid = 1'b0; s_data = '0;

    @(negedge clk);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset m_full", 32'(m_full), 32'd0);
    rstn = 1'b1;

    // Window 4, raw sum
    vecs.push_back(ld(7'd4, 1'b0, 16'd0, 1'b0, 16'd0));
    vecs.push_back(smp(16'd1, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd2, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd3, 1'b1, 22'd1, 1'b0));
    vecs.push_back(smp(16'd4, 1'b1, 22'd3, 1'b0));
    vecs.push_back(smp(16'd5, 1'b1, 22'd6, 1'b0));
    vecs.push_back(smp(16'd6, 1'b1, 22'd10, 1'b1));
    vecs.push_back(idl(1'b1, 22'd14, 1'b1));
    vecs.push_back(idl(1'b1, 22'd18, 1'b1));
    vecs.push_back(idl(1'b0, 22'd0, 1'b0));
    // Window 4, average with recip = 2^16/4
    vecs.push_back(ld(7'd4, 1'b1, 16'd16384, 1'b0, 16'd0));
    vecs.push_back(smp(16'd1, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd2, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd3, 1'b1, 22'd0, 1'b0));
    vecs.push_back(smp(16'd4, 1'b1, 22'd0, 1'b0));
    vecs.push_back(smp(16'd5, 1'b1, 22'd1, 1'b0));
    vecs.push_back(smp(16'd6, 1'b1, 22'd2, 1'b1));
    vecs.push_back(idl(1'b1, 22'd3, 1'b1));
    vecs.push_back(idl(1'b1, 22'd4, 1'b1));
    vecs.push_back(idl(1'b0, 22'd0, 1'b0));
    // Enable gaps: three between samples 2 and 3, one hiding a ready result
    vecs.push_back(ld(7'd4, 1'b0, 16'd0, 1'b0, 16'd0));
    vecs.push_back(smp(16'd1, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd2, 1'b0, 22'd0, 1'b0));
    vecs.push_back(gap());
    vecs.push_back(gap());
    vecs.push_back(gap());
    vecs.push_back(smp(16'd3, 1'b1, 22'd1, 1'b0));
    vecs.push_back(smp(16'd4, 1'b1, 22'd3, 1'b0));
    vecs.push_back(gap());
    vecs.push_back(smp(16'd5, 1'b1, 22'd6, 1'b0));
    vecs.push_back(smp(16'd6, 1'b1, 22'd10, 1'b1));
    vecs.push_back(idl(1'b1, 22'd14, 1'b1));
    vecs.push_back(idl(1'b1, 22'd18, 1'b1));
    vecs.push_back(idl(1'b0, 22'd0, 1'b0));
    // Window length 0 behaves as 1
    vecs.push_back(ld(7'd0, 1'b0, 16'd0, 1'b0, 16'd0));
    vecs.push_back(smp(16'd7, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd3, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd9, 1'b1, 22'd7, 1'b1));
    vecs.push_back(idl(1'b1, 22'd3, 1'b1));
    vecs.push_back(idl(1'b1, 22'd9, 1'b1));
    vecs.push_back(idl(1'b0, 22'd0, 1'b0));
    // Mid-stream reload to window 2 with a coincident (dropped) sample
    vecs.push_back(ld(7'd4, 1'b0, 16'd0, 1'b0, 16'd0));
    vecs.push_back(smp(16'd1, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd2, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd3, 1'b1, 22'd1, 1'b0));
    vecs.push_back(ld(7'd2, 1'b0, 16'd0, 1'b1, 16'd100));
    vecs.push_back(smp(16'd7, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd9, 1'b0, 22'd0, 1'b0));
    vecs.push_back(smp(16'd11, 1'b1, 22'd7, 1'b0));
    vecs.push_back(idl(1'b1, 22'd16, 1'b1));
    vecs.push_back(idl(1'b1, 22'd20, 1'b1));
    vecs.push_back(idl(1'b0, 22'd0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_row(vecs[i], $sformatf("row%0d", i));
    end

    // Full 64-deep window of maximum samples, then 6 more to exercise the wrap
    apply_row(ld(7'd64, 1'b0, 16'd0, 1'b0, 16'd0), "win64 load");
    for (int k = 1; k <= 72; k++) begin
      int j;
      j = k - 2;
      apply_row(row(1'b1, 1'b0, 7'd0, 1'b0, 16'd0, (k <= 70), 16'hFFFF,
                    (k >= 3), 22'(((j < 64) ? j : 64) * 65535), (j >= 64)),
                $sformatf("win64 out%0d", j));
    end
    apply_row(idl(1'b0, 22'd0, 1'b0), "win64 drain");

    // Asynchronous reset with a sample in flight
    en = 1'b1; cfg_load = 1'b0; s_valid = 1'b1; s_data = 16'hFFFF;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async reset m_valid", 32'(m_valid), 32'd0);
    check("async reset m_data", 32'(m_data), 32'd0);
    check("async reset m_full", 32'(m_full), 32'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    apply_row(smp(16'd5, 1'b0, 22'd0, 1'b0), "post-reset a");
    apply_row(smp(16'd5, 1'b0, 22'd0, 1'b0), "post-reset b");
    apply_row(idl(1'b1, 22'd5, 1'b0), "post-reset c");
    apply_row(idl(1'b1, 22'd10, 1'b0), "post-reset d");
    apply_row(idl(1'b0, 22'd0, 1'b0), "post-reset e");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mwi_stream.md
Name: mwi_stream

Overview:
- Parametrised moving-window integrator for the QRS detection chain. Sits after the squaring stage and feeds the adaptive-threshold stage.
- Keeps a running sum over a window length set at run time, up to MAX_WINDOW samples. Each accepted sample adds the new value and subtracts the oldest, so there is no per-cycle adder tree.
- Output is either the raw window sum or a normalised average, with valid and window-full qualifiers.

Parameters:
- DATA_WIDTH, 16, unsigned input sample width (squared signal, never negative).
- MAX_WINDOW, 64, maximum window depth, ≥2.
- RECIP_WIDTH, 16, width of the Q0.RECIP_WIDTH normalisation factor.
- SUM_WIDTH, DATA_WIDTH+$clog2(MAX_WINDOW), accumulator and raw output width; derived, not for override.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, reset, asynchronous, active-low.
- en, in, 1, global enable; low freezes all state.
- cfg_load, in, 1, one-cycle pulse: latch cfg_win_len and flush.
- cfg_win_len, in, $clog2(MAX_WINDOW)+1, window length in samples.
- cfg_avg, in, 1, 0 = raw sum out, 1 = normalised average out; sampled on cfg_load.
- cfg_recip, in, RECIP_WIDTH, normalisation factor ≈ 2^RECIP_WIDTH/win_len; sampled on cfg_load.
- s_valid, in, 1, input sample strobe.
- s_data, in, DATA_WIDTH, input sample.
- m_valid, out, 1, output strobe.
- m_data, out, SUM_WIDTH, sum, or average zero-extended.
- m_full, out, 1, window completely filled for this m_data.

Behaviour:
- Reset: m_valid=0, m_data=0, m_full=0, sum=0, ptr=0, fill count=0, state=FILL. Configuration resets to win_len=MAX_WINDOW, avg=0, recip=0. Buffer contents are don't-care because FILL masks them.
- Window length: cfg_win_len=0 is treated as 1; values above MAX_WINDOW clamp to MAX_WINDOW.
- States:
  - FILL: oldest term forced to 0; fill count increments per accepted sample; go to RUN when count reaches win_len−1 and a sample is accepted.
  - RUN: oldest term = buf[ptr].
- Accepted sample = en & s_valid & ~cfg_load.
- Stage 1, per accepted sample:
  - sum <= sum + s_data − oldest.
  - buf[ptr] <= s_data (read-before-write, same cycle).
  - ptr <= (ptr == win_len−1) ? 0 : ptr+1; wrap is at win_len, not MAX_WINDOW.
- Stage 2:
  - avg=0: m_data=sum.
  - avg=1: m_data=(sum*cfg_recip)>>RECIP_WIDTH, truncating (floor), saturated to 2^DATA_WIDTH−1, zero-extended.
  - m_full = stage-1 state was RUN after the update, i.e. the sample completed or slid a full window.
- Latency: sample accepted at edge t gives m_valid=1 for exactly one cycle after edge t+2.
- Throughput: one sample per clock; no backpressure.
- cfg_load takes priority over a simultaneous s_valid; that sample is dropped. It also:
  - latches the configuration;
  - clears sum, ptr and fill count; forces FILL;
  - kills any in-flight stage-2 result, so m_valid=0 on the following cycle.
- en=0: no state changes; m_valid forced 0; the pending pipeline result is held and emitted when en returns.
- Overflow: impossible in sum mode, since SUM_WIDTH holds MAX_WINDOW·(2^DATA_WIDTH−1).
- Asynchronous reset mid-stream: all state returns to reset values immediately; no m_valid until a new sample is accepted.

Decomposition:
- Package mwi_pkg holds:
  - state enum {FILL, RUN};
  - function clamp_win_len;
  - localparams PTR_W=$clog2(MAX_WINDOW) and SUM_WIDTH formula.
- Sub-module mwi_delay_line is a MAX_WINDOW×DATA_WIDTH circular buffer with asynchronous read at ptr and synchronous write. It owns ptr and its wrap logic and takes win_len as input.

Test Plan:
- win_len=4, avg=0, inputs 1,2,3,4,5,6 → m_data 1,3,6,10,14,18; m_full 0,0,0,1,1,1; each m_valid 2 cycles after its input.
- Same stream, avg=1, recip=16384 → m_data 0,0,1,2,3,4.
- win_len=64, avg=0, 70 samples of 65535 → final m_data 4194240, no wrap error; m_full first high on sample 64.
- Mid-stream cfg_load to win_len=2, issued together with s_valid, then inputs 7,9,11:
  - the coincident sample is dropped;
  - outputs 7,16,20; m_full 0,1,1;
  - m_valid=0 the cycle after cfg_load.
- en held low 3 cycles between samples 2 and 3 of scenario 1 → identical outputs, no m_valid during gap. cfg_win_len=0 → behaves as 1 (m_data = input).
- rstn asserted mid-RUN, then released and inputs 5,5 applied with win_len default 64 → m_data 5,10; m_full 0; no stale sum.
